qbert_cube_tracker: RTL and testbench

Game-side producer of the 28-bit cube colour vector consumed by the map renderer as `e_color_state`. It watches the renderer's one-hot `position_qb` landing vector and the `done_move` strobe and marks the cube Q*bert lands on. It counts coloured cubes, flags level completion, and exposes everything to the NIOS through a small Avalon-MM slave. It sits between the map/colour renderer and the NIOS register bus, replacing software polling of `position_qb`.

---
 rtl/qbert_pkg.sv | 24 ++
 rtl/cube_popcount.sv | 12 +
 rtl/qbert_cube_tracker.sv | 122 ++++++++++++
 tb/tb_qbert_cube_tracker.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/qbert_pkg.sv
// qbert_pkg: shared constants, FSM encoding and register map for the cube tracker.
package qbert_pkg;
  localparam int N_CUBE = 28;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_UPDATE  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;
  localparam logic [1:0] A_COLOR  = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam int C_ARM    = 0;
  localparam int C_CLEAR  = 1;
  localparam int C_ACK    = 2;
  localparam int C_DISARM = 3;
  localparam int SB_COUNT = 0;
  localparam int SB_IDX   = 8;
  localparam int SB_MISS  = 16;
  localparam int SB_DONE  = 17;
  localparam int SB_STATE = 24;
endpackage

// File: rtl/cube_popcount.sv
// cube_popcount: combinational population count of the cube colour vector.
module cube_popcount #(
  parameter int N = 28
) (
  input  logic [N-1:0] vec,
  output logic [4:0]   cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + 5'(vec[i]);
  end
endmodule

// File: rtl/qbert_cube_tracker.sv
// qbert_cube_tracker: marks landed cubes, counts them and exposes state over Avalon-MM.
// Define CUBE_TOGGLE_EN to make a repeat landing clear the cube instead of leaving it set.
module qbert_cube_tracker
  import qbert_pkg::*;
#(
  parameter int N_CUBE = qbert_pkg::N_CUBE,
  parameter int SETTLE = 2
) (
  input  logic              CLK_33,
  input  logic              reset,
  input  logic [N_CUBE-1:0] position_qb,
  input  logic              done_move,
  output logic [N_CUBE-1:0] color_state,
  output logic [4:0]        n_colored,
  output logic              level_done,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata
);
  state_t            state_q, state_d;
  logic [7:0]        settle_q, settle_d;
  logic              done_d_q;
  logic              hit_q, hit_d;
  logic [4:0]        landed_idx_q, landed_idx_d;
  logic              miss_q, miss_d;
  logic [N_CUBE-1:0] color_state_q, color_state_d;
  logic [4:0]        n_colored_q, n_colored_d;
  logic              level_done_q, level_done_d;
  logic [31:0]       avs_readdata_q, avs_readdata_d;
  logic [3:0]        ctrl;
  logic              color_wr, override, rise, one_hot, mark, full_d;
  logic [4:0]        pos_idx;
  logic [N_CUBE-1:0] bit_vec, marked;
  logic [31:0]       status;
  logic              unused_wd;

  assign unused_wd = ^avs_writedata[31:N_CUBE];
  assign bit_vec   = N_CUBE'(1) << landed_idx_q;
`ifdef CUBE_TOGGLE_EN
  assign marked = color_state_q ^ bit_vec;
`else
  assign marked = color_state_q | bit_vec;
`endif

  cube_popcount #(.N(N_CUBE)) u_pop (.vec(color_state_d), .cnt(n_colored_d));

  always_comb begin
    ctrl     = (avs_write && avs_address == A_CTRL) ? avs_writedata[3:0] : 4'd0;
    color_wr = avs_write && avs_address == A_COLOR;
    override = color_wr | ctrl[C_CLEAR];
    rise     = done_move & ~done_d_q;
    one_hot  = |position_qb && ((position_qb & (position_qb - N_CUBE'(1))) == '0);
    pos_idx  = '0;
    for (int i = 0; i < N_CUBE; i++) if (position_qb[i]) pos_idx = 5'(i);
    // A bus write to the colour vector in the UPDATE cycle pre-empts the landing entirely.
    mark          = state_q == ST_UPDATE && hit_q && !override;
    color_state_d = color_wr ? avs_writedata[N_CUBE-1:0] : ctrl[C_CLEAR] ? '0 : mark ? marked : color_state_q;
    landed_idx_d  = (state_q == ST_CAPTURE && one_hot) ? pos_idx : landed_idx_q;
    hit_d         = state_q == ST_CAPTURE ? one_hot : hit_q;
    miss_d        = !ctrl[C_ACK] && (miss_q || (state_q == ST_UPDATE && !hit_q && !override));
    full_d        = n_colored_d == 5'(N_CUBE);
    level_done_d  = (level_done_q && !ctrl[C_ACK]) || (full_d && n_colored_q != 5'(N_CUBE));
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      ST_IDLE:    if (ctrl[C_ARM]) state_d = ST_ARMED;
      ST_ARMED:   if (rise) begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
      ST_SETTLE:  if (settle_q == 8'(SETTLE - 1)) state_d = ST_CAPTURE;
                  else settle_d = settle_q + 8'd1;
      ST_CAPTURE: state_d = ST_UPDATE;
      ST_UPDATE:  state_d = full_d ? ST_DONE : ST_ARMED;
      ST_DONE:    if (ctrl[C_ACK]) state_d = ST_ARMED;
      default:    state_d = ST_IDLE;
    endcase
    if (ctrl[C_DISARM]) state_d = ST_IDLE;
    status                   = '0;
    status[SB_COUNT +: 5]    = n_colored_q;
    status[SB_IDX +: 5]      = landed_idx_q;
    status[SB_MISS]          = miss_q;
    status[SB_DONE]          = level_done_q;
    status[SB_STATE +: 3]    = state_q;
    avs_readdata_d = !avs_read ? avs_readdata_q :
                     avs_address == A_COLOR  ? 32'(color_state_q) :
                     avs_address == A_STATUS ? status : 32'd0;
  end

  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      settle_q       <= '0;
      done_d_q       <= 1'b0;
      hit_q          <= 1'b0;
      landed_idx_q   <= '0;
      miss_q         <= 1'b0;
      color_state_q  <= '0;
      n_colored_q    <= '0;
      level_done_q   <= 1'b0;
      avs_readdata_q <= '0;
    end else begin
      state_q        <= state_d;
      settle_q       <= settle_d;
      done_d_q       <= done_move;
      hit_q          <= hit_d;
      landed_idx_q   <= landed_idx_d;
      miss_q         <= miss_d;
      color_state_q  <= color_state_d;
      n_colored_q    <= n_colored_d;
      level_done_q   <= level_done_d;
      avs_readdata_q <= avs_readdata_d;
    end
  end

  assign color_state  = color_state_q;
  assign n_colored    = n_colored_q;
  assign level_done   = level_done_q;
  assign avs_readdata = avs_readdata_q;
endmodule

// File: tb/tb_qbert_cube_tracker.sv
// tb_qbert_cube_tracker: randomized landings checked against a transaction-level cube model.
module tb_qbert_cube_tracker;
  import qbert_pkg::*;
  localparam int SETTLE = 2;

  logic        CLK_33 = 1'b0;
  logic        reset = 1'b0;
  logic [27:0] position_qb = '0;
  logic        done_move = 1'b0;
  logic [27:0] color_state;
  logic [4:0]  n_colored;
  logic        level_done;
  logic [1:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;

  int vectors = 0;
  int miscompares = 0;

  logic [27:0] m_color;
  logic [4:0]  m_idx;
  logic        m_miss, m_level;
  state_t      m_st;

  qbert_cube_tracker #(.N_CUBE(28), .SETTLE(SETTLE)) dut (
    .CLK_33(CLK_33), .reset(reset), .position_qb(position_qb), .done_move(done_move),
    .color_state(color_state), .n_colored(n_colored), .level_done(level_done),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata)
  );

  always #5 CLK_33 = ~CLK_33;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_33);
    #1;
  endtask

  task automatic model_reset();
    m_color = '0; m_idx = '0; m_miss = 1'b0; m_level = 1'b0; m_st = ST_IDLE;
  endtask

  task automatic set_color(input logic [27:0] c);
    if ($countones(c) == 28 && $countones(m_color) != 28) m_level = 1'b1;
    m_color = c;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
    if (a == A_COLOR) set_color(d[27:0]);
    if (a == A_CTRL) begin
      if (d[1]) set_color('0);
      if (d[2]) begin m_miss = 1'b0; m_level = 1'b0; end
      if (d[0] && m_st == ST_IDLE) m_st = ST_ARMED;
      if (d[2] && m_st == ST_DONE) m_st = ST_ARMED;
      if (d[3]) m_st = ST_IDLE;
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] s, exp;
    check({tag, ".color"}, 32'(color_state), 32'(m_color));
    check({tag, ".count"}, 32'(n_colored), 32'($countones(m_color)));
    check({tag, ".level"}, 32'(level_done), 32'(m_level));
    exp = 32'($countones(m_color)) | (32'(m_idx) << 8) | (32'(m_miss) << 16) |
          (32'(m_level) << 17) | (32'(m_st) << 24);
    rd(A_STATUS, s);
    check({tag, ".status"}, s, exp);
  endtask

  // One jump: the landing is committed SETTLE+3 edges after done_move is raised.
  task automatic jump(input logic [27:0] pos, input bit collide, input logic [27:0] wdata);
    position_qb = pos; done_move = 1'b1;
    repeat (SETTLE + 2) tick();
    if (collide) begin
      avs_address = A_COLOR; avs_writedata = 32'(wdata); avs_write = 1'b1;
    end
    tick();
    avs_write = 1'b0;
    if (m_st == ST_ARMED) begin
      if ($countones(pos) == 1)
        for (int i = 0; i < 28; i++) if (pos[i]) m_idx = 5'(i);
      if (collide) set_color(wdata);
      else if ($countones(pos) == 1) begin
`ifdef CUBE_TOGGLE_EN
        set_color(m_color ^ pos);
`else
        set_color(m_color | pos);
`endif
      end else m_miss = 1'b1;
      m_st = $countones(m_color) == 28 ? ST_DONE : ST_ARMED;
    end else if (collide) set_color(wdata);
    done_move = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] d;
    logic [27:0] p;
    model_reset();
    repeat (3) tick();
    check("rst.color", 32'(color_state), 32'd0);
    check("rst.count", 32'(n_colored), 32'd0);
    check("rst.level", 32'(level_done), 32'd0);
    check("rst.rdata", avs_readdata, 32'd0);
    reset = 1'b1;
    tick();
    check_all("rst");
    jump(28'd1 << 4, 1'b0, '0);
    check_all("idle_ignored");
    wr(A_CTRL, 32'h1);
    jump(28'd1 << 5, 1'b0, '0);
    check_all("basic");
    check("basic.exact", 32'(color_state), 32'h20);
    jump('0, 1'b0, '0);
    check_all("offmap");
    jump(28'h0000_030, 1'b0, '0);
    check_all("multihot");
    wr(A_CTRL, 32'h4);
    check_all("ack_miss");
    for (int n = 0; n < 20; n++) begin
      p = ($urandom_range(0, 7) == 0) ? 28'($urandom) : (28'd1 << $urandom_range(0, 27));
      jump(p, 1'b0, '0);
      check_all("random");
    end
    wr(A_CTRL, 32'h6);
    jump(28'd1 << 9, 1'b1, 28'h3);
    check_all("collide");
    check("collide.exact", 32'(color_state), 32'h3);
    wr(A_CTRL, 32'h2);
    for (int i = 0; i < 28; i++) jump(28'd1 << i, 1'b0, '0);
    check_all("full");
    check("full.level", 32'(level_done), 32'd1);
    wr(A_COLOR, 32'h0);
    jump(28'd1 << 3, 1'b0, '0);
    check_all("done_ignored");
    wr(A_CTRL, 32'h4);
    jump(28'd1 << 3, 1'b0, '0);
    check_all("after_ack");
    wr(A_CTRL, 32'h2);
    jump(28'd1, 1'b0, '0);
    check_all("toggle1");
    jump(28'd1, 1'b0, '0);
    check_all("toggle2");
    wr(A_COLOR, 32'h0ABC_DEF);
    rd(A_COLOR, d);
    check("color_rd", d, 32'h0ABC_DEF);
    rd(2'd3, d);
    check("addr3_rd", d, 32'd0);
    check_all("pre_reset");
    position_qb = 28'd1 << 7; done_move = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    model_reset();
    check("midrst.color", 32'(color_state), 32'd0);
    check("midrst.count", 32'(n_colored), 32'd0);
    check("midrst.level", 32'(level_done), 32'd0);
    check("midrst.rdata", avs_readdata, 32'd0);
    tick();
    reset = 1'b1;
    repeat (6) tick();
    done_move = 1'b0;
    tick();
    check_all("post_rst");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
